mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synchronous data-memory responder: the RAM-side end of the Enable/RW/Address/DataIn/Out data-memory interface that memory_control and the top-level sequencer drive.
- Replaces the zero-latency behavioural RAM with a clocked slave. Adds an accept/complete handshake and programmable wait states so LDR/STR timing becomes cycle-accurate.
- Sits between memory_control/top level and the data storage array.

Parameters:
- ADDR_W, 16, width of Address port.
- DEPTH, 256, number of 32-bit words implemented; addresses >= DEPTH are out of range.
- WAIT_STATES, 1, extra cycles between request accept and completion; legal range 0..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  request strobe; sampled on rising Clk.
- RW  in  1  1 = read (LDR), 0 = write (STR).
- Address  in  ADDR_W  word address.
- DataIn  in  32  write data.
- Out  out  32  read data; holds last completed read.
- Ready  out  1  one-cycle completion pulse.
- Busy  out  1  high from accept until the cycle after Ready.

Behaviour:
- Reset (async, active-high) sets:
  - FSM to IDLE.
  - Out = 32'h0, Ready = 0, Busy = 0, wait counter = 0.
  - Storage array is not cleared.
- FSM states:
  - IDLE: on Enable=1, accept the request. Capture RW, Address and DataIn into request registers. Busy goes 1 next cycle. Go to WAIT if WAIT_STATES>0, else RESPOND.
  - WAIT: counter increments each cycle. At WAIT_STATES-1 go to RESPOND.
  - RESPOND: perform the access using the captured registers.
    - Read: Out <= mem[addr].
    - Write: mem[addr] <= data.
    - Assert Ready for exactly this cycle, then go to IDLE.
- Latency: request accepted at edge N, Ready high during cycle N+1+WAIT_STATES; read data is valid on Out in the same cycle.
- Busy: 1 in WAIT and RESPOND; 0 in IDLE.
- Enable while Busy=1 is ignored: not queued, no error. The requester must hold or re-issue the request.
- Back-to-back requests: Enable high in the RESPOND cycle is ignored; the next accept is possible in the IDLE cycle that follows. Maximum throughput is one access per WAIT_STATES+2 cycles.
- Out changes only on read completion. Writes leave Out unchanged.
- Read-after-write to the same address returns the new data.
- Out-of-range (captured Address >= DEPTH):
  - Read returns 32'h0.
  - Write is dropped.
  - Ready still pulses.
- Address/DataIn changes after accept have no effect on the in-flight access.
- Reset mid-operation: the in-flight access is aborted. A write not yet in RESPOND is not committed; Ready is not produced.
- Array index uses the low clog2(DEPTH) bits only after the range check passes.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- Defined:
  - Adds output port Err (1 bit). Err pulses with Ready when the completed access was out of range.
  - Err also pulses (with Ready) for a write whose captured DataIn contains X/Z in simulation only; synthesis ignores that check.
  - Err resets to 0.
- Undefined: no Err port; out-of-range accesses are silently handled as specified above.

Decomposition:
- Shared package mem_pkg:
  - RW encoding constants MEM_READ=1'b1, MEM_WRITE=1'b0.
  - FSM state typedef (IDLE, WAIT, RESPOND).
  - Default DEPTH/ADDR_W constants, also used by RAM and memory_control.
- One natural sub-module: mem_array (DEPTH x 32 single-port synchronous storage with write enable, no reset). The responder holds the FSM, request registers and counter.

Test Plan:
- Reset then idle, WAIT_STATES=1 -> Out=0, Ready=0, Busy=0; no Ready pulse over 20 cycles with Enable=0.
- Write addr 0..7 with data 32'hAAA0..32'hAAA7, then read addr 3 -> Ready at accept+2 cycles, Out=32'h0000AAA3; Busy high exactly 2 cycles per access.
- Write 32'h12345678 to addr 5, immediately read addr 5 at next IDLE -> Out=32'h12345678. Toggling Address/DataIn during WAIT does not corrupt either access.
- Read addr 300 with DEPTH=256 -> Out=0 and Ready pulses. Write addr 300 then read addr 44 (300 mod 256) -> original data unchanged. With MEM_RESP_ERR_EN, Err pulses with both out-of-range Ready pulses.
- Enable held high continuously with alternating addresses -> exactly one accept per WAIT_STATES+2 cycles; requests during Busy produce no extra Ready.
- Assert Reset during WAIT of a write of 32'hDEAD to addr 2 (previously 32'hAAA2) -> no Ready, Busy=0, subsequent read of addr 2 returns 32'h0000AAA2. Repeat with WAIT_STATES=0 to confirm a single-cycle accept-to-Ready path.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RW encoding, FSM states and
// default geometry also used by the RAM model and memory_control.
package mem_responder_pkg;

    localparam int DATA_W         = 32;
    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_ADDR_W = 16;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    function automatic logic addrInRange(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a data-memory requester and mem_responder.
// The Err line exists only when MEM_RESP_ERR_EN is defined.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic              enable;
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;
    logic              ready;
    logic              busy;
`ifdef MEM_RESP_ERR_EN
    logic              err;

    modport master (
        output enable, rw, address, dataIn,
        input  dataOut, ready, busy, err
    );

    modport slave (
        input  enable, rw, address, dataIn,
        output dataOut, ready, busy, err
    );
`else
    modport master (
        output enable, rw, address, dataIn,
        input  dataOut, ready, busy
    );

    modport slave (
        input  enable, rw, address, dataIn,
        output dataOut, ready, busy
    );
`endif

endinterface

// File: rtl/mem_responder_array.sv
// DEPTH x 32 single-port storage: clocked write, combinational read, never reset.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Clocked data-memory slave with accept/complete handshake and WAIT_STATES wait cycles.
// Optional MEM_RESP_ERR_EN adds an Err pulse for out-of-range (or X-data) accesses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_responder_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic              reqRw_q, reqRw_d;
    logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
    logic [DATA_W-1:0] reqData_q, reqData_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [DATA_W-1:0] out_q, out_d;

    logic              accRw;
    logic [ADDR_W-1:0] accAddr;
    logic [DATA_W-1:0] accData;
    logic              accInRange;
    logic              enterRespond;
    logic              arrayWe;
    logic [DATA_W-1:0] arrayRdata;

    // With zero wait states the access happens on the accept edge itself,
    // so the bus is used directly while idle and the captured copy afterwards.
    assign accRw        = (state_q == IDLE) ? bus.rw      : reqRw_q;
    assign accAddr      = (state_q == IDLE) ? bus.address : reqAddr_q;
    assign accData      = (state_q == IDLE) ? bus.dataIn  : reqData_q;
    assign accInRange   = addrInRange(32'(accAddr), int'(DEPTH));
    assign enterRespond = (state_d == RESPOND) && (state_q != RESPOND);
    assign arrayWe      = enterRespond && (accRw == MEM_WRITE) && accInRange;

    mem_responder_array #(
        .DEPTH (DEPTH)
    ) uArray (
        .clk_i   (clk_i),
        .we_i    (arrayWe),
        .idx_i   (accAddr[IDX_W-1:0]),
        .wdata_i (accData),
        .rdata_o (arrayRdata)
    );

    always_comb begin
        state_d   = state_q;
        reqRw_d   = reqRw_q;
        reqAddr_d = reqAddr_q;
        reqData_d = reqData_q;
        waitCnt_d = waitCnt_q;
        out_d     = out_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    reqRw_d   = bus.rw;
                    reqAddr_d = bus.address;
                    reqData_d = bus.dataIn;
                    waitCnt_d = 4'd0;
                    state_d   = (WAIT_STATES > 0) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                waitCnt_d = waitCnt_q + 4'd1;
                if (waitCnt_q == LAST_WAIT) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Out is loaded as RESPOND is entered so the data is valid alongside Ready.
        if (enterRespond && (accRw == MEM_READ)) begin
            out_d = accInRange ? arrayRdata : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            reqRw_q   <= MEM_READ;
            reqAddr_q <= '0;
            reqData_q <= '0;
            waitCnt_q <= 4'd0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            reqRw_q   <= reqRw_d;
            reqAddr_q <= reqAddr_d;
            reqData_q <= reqData_d;
            waitCnt_q <= waitCnt_d;
            out_q     <= out_d;
        end
    end

    assign bus.dataOut = out_q;
    assign bus.ready   = (state_q == RESPOND);
    assign bus.busy    = (state_q != IDLE);

`ifdef MEM_RESP_ERR_EN
    logic err_q;
    logic dataUnknown;

`ifndef SYNTHESIS
    assign dataUnknown = (accRw == MEM_WRITE) && $isunknown(accData);
`else
    assign dataUnknown = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enterRespond && (!accInRange || dataUnknown);
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against an array-based reference
// model; covers WAIT_STATES=1 and a second instance with WAIT_STATES=0.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int WS    = 1;
    localparam int DEPTH = 256;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst0 = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] refMem   [DEPTH];
    bit          refValid [DEPTH];
    logic [31:0] lastOut;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16)) bus ();
    mem_responder_if #(.ADDR_W(16)) bus0 ();

    mem_responder #(.ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    mem_responder #(.ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (bus0)
    );

    function automatic logic [31:0] expectRead(input int a);
        if (a >= DEPTH) return 32'h0;
        return refMem[a];
    endfunction

    function automatic void modelWrite(input int a, input logic [31:0] d);
        if (a < DEPTH) begin
            refMem[a]   = d;
            refValid[a] = 1'b1;
        end
    endfunction

    // Issue one request, scramble the bus after accept, wait (bounded) for Ready.
    task automatic access(input logic isRead, input int a, input logic [31:0] d,
                          output int lat, output int busyCnt, output logic [31:0] q,
                          output logic e);
        @(negedge clk);
        bus.enable  = 1'b1;
        bus.rw      = isRead;
        bus.address = 16'(a);
        bus.dataIn  = d;
        @(posedge clk);
        #1;
        bus.enable  = 1'b0;
        bus.address = 16'($urandom);
        bus.dataIn  = $urandom;
        lat = 0; busyCnt = 0; q = 'x; e = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.ready === 1'b1) begin
                q = bus.dataOut;
`ifdef MEM_RESP_ERR_EN
                e = bus.err;
`endif
                break;
            end
        end
    endtask

    task automatic access0(input logic isRead, input int a, input logic [31:0] d,
                           output int lat, output int busyCnt, output logic [31:0] q);
        @(negedge clk);
        bus0.enable  = 1'b1;
        bus0.rw      = isRead;
        bus0.address = 16'(a);
        bus0.dataIn  = d;
        @(posedge clk);
        #1;
        bus0.enable  = 1'b0;
        bus0.address = 16'($urandom);
        bus0.dataIn  = $urandom;
        lat = 0; busyCnt = 0; q = 'x;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus0.busy === 1'b1) busyCnt++;
            if (bus0.ready === 1'b1) begin
                q = bus0.dataOut;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int readyCnt = 0;
        int busyCnt  = 0;
        bus.enable  = 1'b0; bus.rw  = MEM_READ; bus.address  = '0; bus.dataIn  = '0;
        bus0.enable = 1'b0; bus0.rw = MEM_READ; bus0.address = '0; bus0.dataIn = '0;
        rst = 1'b1; rst0 = 1'b1;
        #12;
        total++; if (bus.dataOut !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want %h", bus.dataOut, 32'h0); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst = 1'b0; rst0 = 1'b0;
        lastOut = 32'h0;
        repeat (20) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) readyCnt++;
            if (bus.busy !== 1'b0) busyCnt++;
        end
        total++; if (readyCnt !== 0) begin bad++; $display("FAIL idle_ready_pulses: got %0d want 0", readyCnt); end
        total++; if (busyCnt !== 0) begin bad++; $display("FAIL idle_busy_cycles: got %0d want 0", busyCnt); end
    endtask

    task automatic test_write_read();
        int lat, bc;
        logic [31:0] q;
        logic e;
        for (int i = 0; i < 8; i++) begin
            access(MEM_WRITE, i, 32'hAAA0 + 32'(i), lat, bc, q, e);
            modelWrite(i, 32'hAAA0 + 32'(i));
            total++; if (lat !== WS + 1) begin bad++; $display("FAIL write_latency[%0d]: got %0d want %0d", i, lat, WS + 1); end
            total++; if (bc !== WS + 1) begin bad++; $display("FAIL write_busy_cycles[%0d]: got %0d want %0d", i, bc, WS + 1); end
            total++; if (q !== lastOut) begin bad++; $display("FAIL write_keeps_out[%0d]: got %h want %h", i, q, lastOut); end
        end
        access(MEM_READ, 3, 32'h0, lat, bc, q, e);
        lastOut = expectRead(3);
        total++; if (q !== lastOut) begin bad++; $display("FAIL read3_data: got %h want %h", q, lastOut); end
        total++; if (lat !== WS + 1) begin bad++; $display("FAIL read3_latency: got %0d want %0d", lat, WS + 1); end
        total++; if (bc !== WS + 1) begin bad++; $display("FAIL read3_busy_cycles: got %0d want %0d", bc, WS + 1); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_after_ready: got %b want 0", bus.busy); end
    endtask

    task automatic test_read_after_write();
        int lat, bc;
        logic [31:0] q;
        logic e;
        access(MEM_WRITE, 5, 32'h12345678, lat, bc, q, e);
        modelWrite(5, 32'h12345678);
        total++; if (q !== lastOut) begin bad++; $display("FAIL raw_write_out: got %h want %h", q, lastOut); end
        access(MEM_READ, 5, 32'h0, lat, bc, q, e);
        lastOut = expectRead(5);
        total++; if (q !== lastOut) begin bad++; $display("FAIL raw_read_data: got %h want %h", q, lastOut); end
    endtask

    task automatic test_out_of_range();
        int lat, bc;
        logic [31:0] q, d44;
        logic e;
        d44 = $urandom;
        access(MEM_WRITE, 44, d44, lat, bc, q, e);
        modelWrite(44, d44);
        access(MEM_READ, 300, 32'h0, lat, bc, q, e);
        lastOut = expectRead(300);
        total++; if (q !== lastOut) begin bad++; $display("FAIL oor_read_data: got %h want %h", q, lastOut); end
        total++; if (lat !== WS + 1) begin bad++; $display("FAIL oor_read_ready: got latency %0d want %0d", lat, WS + 1); end
`ifdef MEM_RESP_ERR_EN
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_read_err: got %b want 1", e); end
`endif
        access(MEM_WRITE, 300, $urandom, lat, bc, q, e);
        total++; if (lat !== WS + 1) begin bad++; $display("FAIL oor_write_ready: got latency %0d want %0d", lat, WS + 1); end
`ifdef MEM_RESP_ERR_EN
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_write_err: got %b want 1", e); end
`endif
        access(MEM_READ, 44, 32'h0, lat, bc, q, e);
        lastOut = expectRead(44);
        total++; if (q !== lastOut) begin bad++; $display("FAIL alias44_data: got %h want %h", q, lastOut); end
`ifdef MEM_RESP_ERR_EN
        total++; if (e !== 1'b0) begin bad++; $display("FAIL inrange_err: got %b want 0", e); end
`endif
    endtask

    task automatic test_random();
        int lat, bc, a;
        logic isRead;
        logic [31:0] q, d;
        logic e;
        for (int n = 0; n < 40; n++) begin
            a      = int'($urandom_range(0, 299));
            isRead = 1'($urandom_range(0, 1));
            if (isRead && a < DEPTH && !refValid[a]) isRead = MEM_WRITE;
            d = $urandom;
            access(isRead, a, d, lat, bc, q, e);
            if (isRead) lastOut = expectRead(a);
            else modelWrite(a, d);
            total++; if (q !== lastOut) begin bad++; $display("FAIL random_out[%0d] addr %0d rw %b: got %h want %h", n, a, isRead, q, lastOut); end
            total++; if (lat !== WS + 1) begin bad++; $display("FAIL random_latency[%0d]: got %0d want %0d", n, lat, WS + 1); end
        end
    endtask

    // Enable held high: accepts land every WS+2 edges starting at edge 0.
    task automatic test_back_to_back();
        int addrAt [36];
        int k;
        bit expReady;
        logic [31:0] expData;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            k = j - (WS + 1);
            expReady = (k >= 0) && (k % (WS + 2) == 0) && (k < 30);
            total++; if (bus.ready !== expReady) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", j, bus.ready, expReady); end
            if (expReady) begin
                expData = expectRead(addrAt[k]);
                lastOut = expData;
                total++; if (bus.dataOut !== expData) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", j, bus.dataOut, expData); end
            end
            addrAt[j]   = (j % 2 == 1) ? 3 : 4;
            bus.enable  = (j < 30);
            bus.rw      = MEM_READ;
            bus.address = 16'(addrAt[j]);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat, bc, readyCnt;
        logic [31:0] q;
        logic e;
        access(MEM_WRITE, 2, 32'h0000AAA2, lat, bc, q, e);
        modelWrite(2, 32'h0000AAA2);
        @(negedge clk);
        bus.enable = 1'b1; bus.rw = MEM_WRITE; bus.address = 16'd2; bus.dataIn = 32'h0000DEAD;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        lastOut = 32'h0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus.ready); end
        total++; if (bus.dataOut !== 32'h0) begin bad++; $display("FAIL abort_out: got %h want %h", bus.dataOut, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
        readyCnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) readyCnt++;
        end
        total++; if (readyCnt !== 0) begin bad++; $display("FAIL abort_no_ready: got %0d want 0", readyCnt); end
        access(MEM_READ, 2, 32'h0, lat, bc, q, e);
        lastOut = expectRead(2);
        total++; if (q !== 32'h0000AAA2) begin bad++; $display("FAIL abort_not_committed: got %h want %h", q, 32'h0000AAA2); end
    endtask

    task automatic test_zero_wait();
        int lat, bc;
        logic [31:0] q, d;
        d = $urandom;
        access0(MEM_WRITE, 9, d, lat, bc, q);
        total++; if (lat !== 1) begin bad++; $display("FAIL ws0_write_latency: got %0d want 1", lat); end
        total++; if (bc !== 1) begin bad++; $display("FAIL ws0_write_busy: got %0d want 1", bc); end
        total++; if (q !== 32'h0) begin bad++; $display("FAIL ws0_write_out: got %h want %h", q, 32'h0); end
        access0(MEM_READ, 9, 32'h0, lat, bc, q);
        total++; if (q !== d) begin bad++; $display("FAIL ws0_read_data: got %h want %h", q, d); end
        total++; if (lat !== 1) begin bad++; $display("FAIL ws0_read_latency: got %0d want 1", lat); end
        access0(MEM_READ, 1000, 32'h0, lat, bc, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL ws0_oor_data: got %h want %h", q, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_after_write();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
